// File: rtl/firmware_pkg.sv
// Shared firmware constants, loader FSM states and error codes.
// Used by the loader, its bus interface and the firmware memory.
package firmware_pkg;

   localparam logic [13:0] FIRMWARE_SIZE = 14'h3000;
   localparam int          ADDR_WIDTH    = $clog2(FIRMWARE_SIZE);
   localparam logic [7:0]  SYNC_BYTE     = 8'hA5;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_CSUM  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM
   } ld_state_t;

endpackage

// File: rtl/firmware_loader_m_if.sv
// Loader bus: host byte stream (rx_data/rx_valid/rx_ready) plus
// firmware write port (wr_address/wr_data/wr_enable).
// master = host/memory side, slave = loader side.
interface firmware_loader_m_if;
   import firmware_pkg::*;

   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [ADDR_WIDTH-1:0] wr_address;
   logic [7:0]            wr_data;
   logic                  wr_enable;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, wr_address, wr_data, wr_enable
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, wr_address, wr_data, wr_enable
   );

endinterface

// File: rtl/firmware_loader_m.sv
// Framed byte-stream firmware writer: SYNC ADDR(2) LEN(2) payload [CSUM].
// Ports: clk, rst_n (async low), bus (slave: rx stream in, write port out),
// busy/done/error/error_code status. Macro FIRMWARE_LOADER_CHECKSUM_EN
// enables the trailing checksum byte and its check.
module firmware_loader_m
   import firmware_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   firmware_loader_m_if.slave  bus,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [1:0]          error_code
);

   ld_state_t             state, state_n;
   logic [15:0]           addr_q, addr_n;
   logic [15:0]           len_q, len_n;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_n;
   logic [7:0]            wr_data_q, wr_data_n;
   logic                  wr_en_q, wr_en_n;
   logic                  busy_n, done_n, error_n;
   logic [1:0]            code_n;
   logic [15:0]           len_full;
   logic [16:0]           end_addr;
   logic                  hs;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_n;
`endif

   assign bus.rx_ready   = 1'b1;
   assign bus.wr_address = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.wr_enable  = wr_en_q;

   assign hs       = bus.rx_valid & bus.rx_ready;
   assign len_full = {len_q[15:8], bus.rx_data};
   // 17-bit end address so a large ADDR+LEN cannot wrap past the check
   assign end_addr = {1'b0, addr_q} + {1'b0, len_full};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         error_code <= ERR_NONE;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state      <= state_n;
         addr_q     <= addr_n;
         len_q      <= len_n;
         wr_addr_q  <= wr_addr_n;
         wr_data_q  <= wr_data_n;
         wr_en_q    <= wr_en_n;
         busy       <= busy_n;
         done       <= done_n;
         error      <= error_n;
         error_code <= code_n;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
         csum_q     <= csum_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      addr_n    = addr_q;
      len_n     = len_q;
      wr_addr_n = wr_addr_q;
      wr_data_n = wr_data_q;
      wr_en_n   = 1'b0;
      busy_n    = busy;
      done_n    = 1'b0;
      error_n   = 1'b0;
      code_n    = error_code;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      csum_n    = csum_q;
      if (hs && state != S_IDLE)
         csum_n = csum_q + bus.rx_data;
`endif
      if (hs) begin
         unique case (state)
            S_IDLE: begin
               if (bus.rx_data == SYNC_BYTE) begin
                  state_n = S_ADDR_HI;
                  busy_n  = 1'b1;
                  code_n  = ERR_NONE;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
                  csum_n  = '0;
`endif
               end
            end
            S_ADDR_HI: begin
               addr_n[15:8] = bus.rx_data;
               state_n      = S_ADDR_LO;
            end
            S_ADDR_LO: begin
               addr_n[7:0] = bus.rx_data;
               state_n     = S_LEN_HI;
            end
            S_LEN_HI: begin
               len_n[15:8] = bus.rx_data;
               state_n     = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_n = len_full;
               if (addr_q[15:ADDR_WIDTH] != '0 ||
                   end_addr > {3'b000, FIRMWARE_SIZE}) begin
                  error_n = 1'b1;
                  code_n  = ERR_RANGE;
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
               end else if (len_full == '0) begin
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
                  state_n = S_CSUM;
`else
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
`endif
               end else begin
                  state_n = S_DATA;
               end
            end
            S_DATA: begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr_q[ADDR_WIDTH-1:0];
               wr_data_n = bus.rx_data;
               addr_n    = addr_q + 16'd1;
               len_n     = len_q - 16'd1;
               if (len_q == 16'd1) begin
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
                  state_n = S_CSUM;
`else
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  state_n = S_IDLE;
`endif
               end
            end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (csum_n == 8'h00) begin
                  done_n = 1'b1;
               end else begin
                  error_n = 1'b1;
                  code_n  = ERR_CSUM;
               end
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_firmware_loader_m.sv
// Scoreboard bench for firmware_loader_m: writes and done/error events
// are queued as frames are driven and popped by a cycle monitor.
module tb_firmware_loader_m;
   import firmware_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] error_code;

   int checks   = 0;
   int failures = 0;

   logic [21:0] exp_wr[$];
   logic [3:0]  exp_ev[$];

   firmware_loader_m_if bus();

   firmware_loader_m dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .error_code (error_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      logic [21:0] w;
      logic [3:0]  e;
      #1;
      checks++;
      if (bus.rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL rx_ready got=%b want=1", bus.rx_ready);
      end
      if (bus.wr_enable === 1'b1) begin
         checks++;
         if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h",
                     bus.wr_address, bus.wr_data);
         end else begin
            w = exp_wr.pop_front();
            if ({bus.wr_address, bus.wr_data} !== w) begin
               failures++;
               $display("FAIL write got=%h/%h want=%h/%h",
                        bus.wr_address, bus.wr_data, w[21:8], w[7:0]);
            end
         end
      end
      if (done === 1'b1 || error === 1'b1) begin
         checks++;
         if (exp_ev.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event done=%b error=%b code=%0d",
                     done, error, error_code);
         end else begin
            e = exp_ev.pop_front();
            if ({done, error, error_code} !== e) begin
               failures++;
               $display("FAIL event got=%b%b/%0d want=%b%b/%0d",
                        done, error, error_code, e[3], e[2], e[1:0]);
            end
         end
      end
   end

   // caller is at a negedge; returns at the negedge after the handshake
   task automatic send_byte(input logic [7:0] b, input int gmax);
      repeat ($urandom_range(0, gmax)) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                             input logic [7:0] first, input bit bad,
                             input int gmax);
      logic [16:0] end_a;
      logic [15:0] ai;
      logic [7:0]  d, cs;
      bit          rng, csum_err;
      end_a    = {1'b0, a} + {1'b0, n};
      rng      = (a[15:14] != 2'b00) || (end_a > 17'h03000);
      cs       = a[15:8] + a[7:0] + n[15:8] + n[7:0];
      csum_err = 1'b0;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      csum_err = bad;
`endif
      if (rng) begin
         exp_ev.push_back({2'b01, ERR_RANGE});
      end else begin
         d  = first;
         ai = a;
         for (int i = 0; i < int'(n); i++) begin
            exp_wr.push_back({ai[13:0], d});
            cs = cs + d;
            d  = d + 8'h11;
            ai = ai + 16'd1;
         end
         if (csum_err) exp_ev.push_back({2'b01, ERR_CSUM});
         else          exp_ev.push_back({2'b10, ERR_NONE});
      end
      send_byte(SYNC_BYTE, gmax);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_sync got=%b want=1", busy);
      end
      send_byte(a[15:8], gmax);
      send_byte(a[7:0], gmax);
      send_byte(n[15:8], gmax);
      send_byte(n[7:0], gmax);
      if (!rng) begin
         d = first;
         for (int i = 0; i < int'(n); i++) begin
            send_byte(d, gmax);
            d = d + 8'h11;
         end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
         send_byte(8'h00 - cs + {7'd0, bad}, gmax);
`endif
      end
      checks++;
      if (exp_ev.size() != 0 || exp_wr.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL frame_end a=%h n=%0d pend_ev=%0d pend_wr=%0d busy=%b want=0/0/0",
                  a, n, exp_ev.size(), exp_wr.size(), busy);
         exp_ev.delete();
         exp_wr.delete();
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, error, error_code} !== 5'b0) begin
         failures++;
         $display("FAIL reset_status got=%b%b%b%0d want=0000",
                  busy, done, error, error_code);
      end
      checks++;
      if ({bus.wr_enable, bus.wr_address, bus.wr_data} !== 23'b0) begin
         failures++;
         $display("FAIL reset_write got=%b/%h/%h want=0/0/0",
                  bus.wr_enable, bus.wr_address, bus.wr_data);
      end
      checks++;
      if (bus.rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b want=1", bus.rx_ready);
      end
   endtask

   task automatic test_basic();
      send_frame(16'h0010, 16'd2, 8'h11, 1'b0, 0);
   endtask

   task automatic test_csum_error();
      send_frame(16'h0010, 16'd2, 8'h11, 1'b1, 0);
      checks++;
      if (error_code !== ERR_CSUM) begin
         failures++;
         $display("FAIL csum_code_held got=%0d want=2", error_code);
      end
   endtask

   task automatic test_range();
      send_frame(16'h2FFF, 16'd2, 8'h11, 1'b0, 0);
      checks++;
      if (error_code !== ERR_RANGE) begin
         failures++;
         $display("FAIL range_code_held got=%0d want=1", error_code);
      end
      send_frame(16'h0000, 16'd0, 8'h00, 1'b0, 0);
      checks++;
      if (error_code !== ERR_NONE) begin
         failures++;
         $display("FAIL code_cleared got=%0d want=0", error_code);
      end
      send_frame(16'h2FFE, 16'd2, 8'h5A, 1'b0, 0);
      send_frame(16'h3000, 16'd0, 8'h00, 1'b0, 0);
      send_frame(16'h4000, 16'd0, 8'h00, 1'b0, 0);
      send_frame(16'h0000, 16'h3001, 8'h00, 1'b0, 0);
   endtask

   task automatic test_noise();
      logic [7:0] nz [3];
      nz[0] = 8'h00;
      nz[1] = 8'hFF;
      nz[2] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         send_byte(nz[i], 0);
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL noise_busy byte=%h got=%b want=0", nz[i], busy);
         end
      end
      send_frame(16'h0000, 16'd0, 8'h00, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      exp_wr.push_back({14'h0100, 8'h33});
      send_byte(SYNC_BYTE, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      send_byte(8'h33, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, error, error_code, bus.wr_enable} !== 6'b0 ||
          {bus.wr_address, bus.wr_data} !== 22'b0) begin
         failures++;
         $display("FAIL async_reset got=%b%b%b%0d%b/%h/%h want=all zero",
                  busy, done, error, error_code, bus.wr_enable,
                  bus.wr_address, bus.wr_data);
      end
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_first_write pending=%0d want=0",
                  exp_wr.size());
         exp_wr.delete();
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_busy got=%b want=0", busy);
      end
      send_frame(16'h0020, 16'd1, 8'h77, 1'b0, 0);
   endtask

   task automatic test_gaps();
      send_frame(16'h0200, 16'd8, 8'h01, 1'b0, 5);
      send_frame(16'h0010, 16'd2, 8'h11, 1'b0, 5);
   endtask

   task automatic test_back_to_back();
      send_frame(16'h0300, 16'd3, 8'hA5, 1'b0, 0);
      send_frame(16'h0400, 16'd2, 8'hA5, 1'b0, 0);
      send_frame(16'h0500, 16'd0, 8'h00, 1'b0, 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      test_csum_error();
`endif
      test_range();
      test_noise();
      test_reset_mid();
      test_gaps();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
